// File: rtl/riscape_fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states and the
// {pc, instr} record carried through the prefetch FIFO.
package riscape_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits of a PC.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetch entries; read/write pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module fetch_fifo
  import riscape_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  fetch_entry_t  i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  fetch_entry_t  r_mem [DEPTH];
  logic          w_pop_en;
  logic          w_push_en;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_en  = i_pop && !o_empty;
  // A full FIFO may accept a push in the same cycle its head is popped.
  assign w_push_en = i_push && (!o_full || w_pop_en);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + CW'(1);
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word fetches under a credit limit,
// buffers in-order responses with their PCs, and discards stale fetches on redirect.
module fetch_prefetch_buffer
  import riscape_fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [XLEN-1:0] r_pend_addr;
  logic            r_pending;
  logic            r_pend_stale;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_out_nxt;
  logic [CW-1:0]   w_discard_nxt;
  logic [CW-1:0]   w_count;
  logic [XLEN-1:0] w_target;
  logic            w_credit;
  logic            w_gnt;
  logic            w_hold;
  logic            w_keep;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;

  assign w_target = word_align(redirect_pc_i);

  // Buffered plus in-flight words may never exceed the FIFO size.
  assign w_credit   = (SW'(w_count) + SW'(r_outstanding)) < SW'(DEPTH);
  assign mem_req_o  = r_pending || ((r_state != IDLE) && w_credit);
  assign mem_addr_o = r_pending ? r_pend_addr : r_fetch_pc;
  assign w_gnt      = mem_req_o && mem_gnt_i;
  assign w_hold     = mem_req_o && !mem_gnt_i;

  assign w_keep        = mem_rvalid_i && (r_discard == '0);
  assign w_push        = w_keep && !redirect_i;
  assign instr_valid_o = !w_fifo_empty && !redirect_i;
  assign w_pop         = instr_valid_o && instr_ready_i;
  assign w_push_data   = '{pc: r_resp_pc, instr: mem_rdata_i};
  assign instr_o       = w_head.instr;
  assign instr_pc_o    = w_head.pc;

  assign w_out_nxt = r_outstanding + CW'(w_gnt) - CW'(mem_rvalid_i);

  // On redirect everything still in flight, including a held request, is dropped.
  always_comb begin
    w_discard_nxt = r_discard;
    if (redirect_i) begin
      w_discard_nxt = w_out_nxt + CW'(w_hold);
    end else if (mem_rvalid_i && (r_discard != '0)) begin
      w_discard_nxt = r_discard - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = FETCH;
      FETCH:   if (redirect_i && (r_outstanding != '0)) w_state_nxt = FLUSH;
      FLUSH:   if (w_discard_nxt == '0) w_state_nxt = FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A held request that outlived a redirect carries an old address, so its
  // grant must not advance the new fetch PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_pend_addr   <= RESET_PC;
      r_pending     <= 1'b0;
      r_pend_stale  <= 1'b0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      r_discard     <= w_discard_nxt;
      r_pending     <= w_hold;
      r_pend_stale  <= w_hold && (redirect_i || r_pend_stale);
      if (w_hold) begin
        r_pend_addr <= mem_addr_o;
      end
      if (redirect_i) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
      end else begin
        if (w_gnt && !(r_pending && r_pend_stale)) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_keep) begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  // The credit rule makes an unpopped push into a full FIFO unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(w_push && w_fifo_full && !w_pop));

endmodule
